alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
// - Shares one combinational ALU_16Bit instance between two requesters (req0, req1) via round-robin arbitration.
// - Registers operands and op, holds the ALU inputs stable for a fixed settle window, then captures the result and flags.
// - Returns one tagged response per accepted request.
// - Sits between the CPU control path / DMA-style helpers and the ALU datapath.
// PARAMETERS
// - DATA_W       16  operand/result width; fixed to 16 to match the ALU
// - MD_WAIT      2   extra settle cycles for mul (op 100) and div (op 101); legal range 0..15
// PORTS
// - clk            in   1       system clock, rising edge
// - rst            in   1       synchronous reset, active-high
// - req0_valid     in   1       requester 0 has an op
// - req0_ready     out  1       requester 0 op accepted this cycle
// - req0_a/req0_b  in   16/16   requester 0 operands
// - req0_op        in   3       000 add, 001 sub, 010 and, 011 or, 100 mul, 101 div
// - req1_*         (same set as req0_*, for requester 1)
// - resp_valid     out  1       response available
// - resp_ready     in   1       consumer takes the response
// - resp_id        out  1       requester index (0/1) the response belongs to
// - resp_result    out  16      captured ALU result
// - resp_flags     out  4       {C, V, N, Z}
// - resp_err       out  1       illegal op (110/111) or divide by zero
// - alu_a/alu_b    out  16/16   to ALU operand inputs
// - alu_sub        out  1       to ALU sub; =1 iff latched op == 001
// - alu_op_select  out  3       to ALU op_select
// - alu_result     in   16      from ALU
// - alu_cout       in   1       from ALU
// - alu_overflow   in   1       from ALU
// - stat0_cnt/stat1_cnt  out  16/16  completed-op counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE, rr_ptr=0 (req0 preferred). All outputs 0, including alu_*, resp_*, stat*.
// - Reset mid-operation abandons the op: no response is issued, and the requester must re-issue.
// - FSM states: IDLE, EXEC, WAIT, RESP.
// - IDLE: grant = only valid requester; if both valid, grant = rr_ptr.
//   - reqN_ready=1 (combinational) only for the granted N, only in IDLE; transfer occurs on valid&ready.
//   - On transfer: latch a, b, op, id into alu_* regs; rr_ptr <= ~id.
//   - Next state: op 110/111, or op 101 with b==0 -> RESP (err path); else -> EXEC.
// - EXEC: 1 cycle, ALU inputs stable.
//   - add/sub/and/or: capture at end of EXEC, then -> RESP.
//   - mul/div with MD_WAIT>0: -> WAIT; with MD_WAIT==0: capture at end of EXEC.
// - WAIT: down-counter loaded with MD_WAIT-1; capture when it reaches 0, then -> RESP.
// - Capture values:
//   - resp_result = alu_result.
//   - C/V = alu_cout/alu_overflow for add/sub, 0 otherwise.
//   - N = result[15]; Z = (result==0), computed here from alu_result.
//   - resp_err = 0.
// - Err path: resp_result=0, resp_flags=0, resp_err=1; the ALU result is not sampled.
// - RESP: resp_valid=1; resp_* held stable until resp_valid&resp_ready, then -> IDLE. No accept in the same cycle.
// - Latency (accept edge = cycle T):
//   - resp_valid at T+2 for add/sub/and/or; T+2+MD_WAIT for mul/div; T+1 for the err path.
// - Throughput: one op per 3 cycles minimum (add/sub/and/or with resp_ready held high).
// - alu_* outputs hold the last latched values while IDLE/RESP; there is no bypass.
// - Arithmetic: all widths are 16 bits; mul keeps the low 16 bits; div is an unsigned quotient (ALU defined).
// CONFIGURATION
// - ALU_ARB_STATS_EN defined:
//   - stat0_cnt/stat1_cnt increment on each resp handshake for the matching resp_id, err responses included.
//   - Counters saturate at 16'hFFFF and are cleared by rst.
// - ALU_ARB_STATS_EN undefined: stat0_cnt/stat1_cnt tied to 0 and no counter flops are inferred.
// TESTING
// - Single add: req0 a=0x7FFF b=0x0001 op=000, resp_ready=1 -> resp at T+2: result=0x8000, flags C0 V1 N1 Z0, id=0.
// - Contention: req0 and req1 both valid from reset -> grants 0,1,0,1 alternate; each requester gets exactly one grant per round.
// - Mul latency, MD_WAIT=2: a=3 b=5 op=100 -> resp_valid at T+4, result=15.
// - Err paths:
//   - op=101 b=0 -> resp at T+1, err=1, result=0, flags=0.
//   - op=111 -> same response.
// - Backpressure: resp_ready=0 for 5 cycles -> resp_* stable; reqN_ready=0 throughout; release -> IDLE the next cycle.
// - Reset mid-WAIT: rst for 1 cycle -> all outputs 0, no resp_valid, rr_ptr=0; with STATS_EN, counters = 0.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// ============================================================================
// alu_req_arbiter_if
// ----------------------------------------------------------------------------
// Bundles every handshake/bus signal around the shared ALU arbiter so the
// arbiter and its environment connect through a single port.
//
// Signal groups:
//   req0_* / req1_*  : requester valid/ready handshake, operands a/b, op code
//   resp_*           : tagged response (valid/ready, id, result, flags, err)
//   alu_*            : operands/controls to the combinational ALU and its
//                      result/carry/overflow coming back
//   stat0/stat1_cnt  : completed-op counters (zero unless ALU_ARB_STATS_EN)
//
// Modports:
//   slave  : the arbiter side (consumes requests, drives responses and ALU)
//   master : the environment side (requesters, response consumer, ALU)
// ============================================================================
interface alu_req_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [2:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        req1_op;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_result;
    logic [3:0]        resp_flags;
    logic              resp_err;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_sub;
    logic [2:0]        alu_op_select;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              alu_overflow;

    logic [15:0]       stat0_cnt;
    logic [15:0]       stat1_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_id, resp_result, resp_flags, resp_err,
        input  resp_ready,
        output alu_a, alu_b, alu_sub, alu_op_select,
        input  alu_result, alu_cout, alu_overflow,
        output stat0_cnt, stat1_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_id, resp_result, resp_flags, resp_err,
        output resp_ready,
        input  alu_a, alu_b, alu_sub, alu_op_select,
        output alu_result, alu_cout, alu_overflow,
        input  stat0_cnt, stat1_cnt
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// alu_req_arbiter
// ----------------------------------------------------------------------------
// Shares one combinational 16-bit ALU between two requesters using
// round-robin arbitration. An accepted request is latched onto the ALU
// inputs, held for a fixed settle window (longer for mul/div), and the
// result plus {C,V,N,Z} flags are captured into a tagged response that is
// held until the consumer takes it. Illegal ops and divide-by-zero skip the
// ALU entirely and answer with resp_err=1.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : alu_req_arbiter_if.slave (requests, response, ALU link, stats)
//
// Parameters:
//   DATA_W  : operand/result width, fixed at 16 to match the ALU
//   MD_WAIT : extra settle cycles for mul (100) and div (101), 0..15
//
// Optional feature macro: ALU_ARB_STATS_EN
//   defined   -> per-requester saturating completed-op counters
//   undefined -> stat0_cnt/stat1_cnt tied to zero, no counter flops
// ============================================================================
module alu_req_arbiter #(
    parameter int DATA_W  = 16,
    parameter int MD_WAIT = 2
) (
    input logic              clk,
    input logic              rst,
    alu_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam bit       HAS_WAIT  = (MD_WAIT > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(MD_WAIT - 1) : 4'd0;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              id_q, id_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;
    logic [3:0]        resp_flags_q, resp_flags_d;
    logic              resp_err_q, resp_err_d;

    logic              grant_id;
    logic              take;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [2:0]        sel_op;
    logic              sel_err;
    logic              is_md;
    logic              is_addsub;
    logic [3:0]        cap_flags;
    logic              capture;
    logic              resp_fire;

    // Arbitration: a lone valid requester wins outright; on contention the
    // round-robin pointer decides. Acceptance is only possible in IDLE and
    // never while reset is held, so no transfer can slip past a reset.
    always_comb begin
        grant_id = (bus.req0_valid & bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
        take     = (state_q == IDLE) & ~rst & (bus.req0_valid | bus.req1_valid);
        sel_a    = grant_id ? bus.req1_a  : bus.req0_a;
        sel_b    = grant_id ? bus.req1_b  : bus.req0_b;
        sel_op   = grant_id ? bus.req1_op : bus.req0_op;
        // Ops 110/111 and div by zero never reach the ALU.
        sel_err  = (sel_op[2:1] == 2'b11) | ((sel_op == 3'b101) & (sel_b == '0));
    end

    assign bus.req0_ready = take & ~grant_id;
    assign bus.req1_ready = take &  grant_id;

    // Carry/overflow are only meaningful for add/sub; N and Z are derived
    // locally from the result rather than trusted from the ALU.
    assign is_md     = (op_q == 3'b100) | (op_q == 3'b101);
    assign is_addsub = (op_q[2:1] == 2'b00);
    assign cap_flags = {is_addsub & bus.alu_cout,
                        is_addsub & bus.alu_overflow,
                        bus.alu_result[DATA_W-1],
                        (bus.alu_result == '0)};
    assign resp_fire = resp_valid_q & bus.resp_ready;

    // Next-state logic for the IDLE -> EXEC -> [WAIT] -> RESP sequence.
    // Capturing is shared between the end of EXEC and the end of WAIT.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        wait_cnt_d    = wait_cnt_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        resp_err_d    = resp_err_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    a_d      = sel_a;
                    b_d      = sel_b;
                    op_d     = sel_op;
                    id_d     = grant_id;
                    rr_ptr_d = ~grant_id;
                    if (sel_err) begin
                        state_d       = RESP;
                        resp_valid_d  = 1'b1;
                        resp_id_d     = grant_id;
                        resp_result_d = '0;
                        resp_flags_d  = 4'd0;
                        resp_err_d    = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (is_md && HAS_WAIT) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    capture = 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    capture = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_fire) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d       = RESP;
            resp_valid_d  = 1'b1;
            resp_id_d     = id_q;
            resp_result_d = bus.alu_result;
            resp_flags_d  = cap_flags;
            resp_err_d    = 1'b0;
        end
    end

    // All FSM and datapath state; reset abandons any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= 3'd0;
            id_q          <= 1'b0;
            wait_cnt_q    <= 4'd0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= 4'd0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            id_q          <= id_d;
            wait_cnt_q    <= wait_cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // ALU inputs come straight from the latched request, so they stay
    // stable for the whole settle window and hold while IDLE/RESP.
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.alu_op_select = op_q;
    assign bus.alu_sub       = (op_q == 3'b001);

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_flags  = resp_flags_q;
    assign bus.resp_err    = resp_err_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat0_q, stat0_d;
    logic [15:0] stat1_q, stat1_d;

    // Count every delivered response per requester, error responses too,
    // saturating rather than wrapping.
    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (resp_fire) begin
            if (!resp_id_q && (stat0_q != 16'hFFFF)) stat0_d = stat0_q + 16'd1;
            if ( resp_id_q && (stat1_q != 16'hFFFF)) stat1_d = stat1_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat0_q <= 16'd0;
            stat1_q <= 16'd0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign bus.stat0_cnt = stat0_q;
    assign bus.stat1_cnt = stat1_q;
`else
    assign bus.stat0_cnt = 16'd0;
    assign bus.stat1_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// tb_alu_req_arbiter
// ----------------------------------------------------------------------------
// Scoreboard bench for alu_req_arbiter. A behavioural ALU drives the ALU
// link; a reference model predicts grants, results, flags and response
// timing from plain arithmetic. Grants push expected responses into a
// queue; the response monitor pops and compares them as they appear.
// ============================================================================
module tb_alu_req_arbiter;

    localparam int MD_WAIT = 2;

    typedef struct {
        logic        id;
        logic [15:0] result;
        logic [3:0]  flags;
        logic        err;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t sbq[$];
    bit   busy;
    bit   pref;
    bit   seen_rv;
    int   cnt0;
    int   cnt1;
    bit   rand_done;

    logic g0;
    logic g1;
    exp_t front;

    alu_req_arbiter_if #(.DATA_W(16)) bus ();

    alu_req_arbiter #(.DATA_W(16), .MD_WAIT(MD_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural ALU; carry/overflow carry junk for non-add/sub ops so the
    // arbiter's masking is observable.
    logic [16:0] alu_wide;
    logic [15:0] alu_r;
    logic        alu_c;
    logic        alu_v;

    always_comb begin
        alu_wide = 17'd0;
        alu_r    = 16'd0;
        alu_c    = ^bus.alu_a;
        alu_v    = ~(^bus.alu_b);
        case (bus.alu_op_select)
            3'd0: begin
                alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                alu_r    = alu_wide[15:0];
                alu_c    = alu_wide[16];
                alu_v    = (bus.alu_a[15] == bus.alu_b[15]) && (alu_r[15] != bus.alu_a[15]);
            end
            3'd1: begin
                alu_wide = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
                alu_r    = alu_wide[15:0];
                alu_c    = alu_wide[16];
                alu_v    = (bus.alu_a[15] != bus.alu_b[15]) && (alu_r[15] != bus.alu_a[15]);
            end
            3'd2: alu_r = bus.alu_a & bus.alu_b;
            3'd3: alu_r = bus.alu_a | bus.alu_b;
            3'd4: alu_r = bus.alu_a * bus.alu_b;
            3'd5: alu_r = (bus.alu_b != 16'd0) ? bus.alu_a / bus.alu_b : 16'hFFFF;
            default: alu_r = 16'hDEAD;
        endcase
    end

    assign bus.alu_result   = alu_r;
    assign bus.alu_cout     = alu_c;
    assign bus.alu_overflow = alu_v;

    // Reference model: expected response for one accepted request, from
    // integer arithmetic; due is the cycle count at which resp_valid shows.
    function automatic exp_t refModel(input logic id, input logic [15:0] a,
                                      input logic [15:0] b, input logic [2:0] op,
                                      input int now);
        exp_t        e;
        int unsigned ua;
        int unsigned ub;
        int          sa;
        int          sb;
        longint      prod;
        logic        c;
        logic        v;
        int          lat;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        e.id     = id;
        e.result = 16'd0;
        e.flags  = 4'd0;
        e.err    = 1'b0;
        if (op >= 3'd6 || (op == 3'd5 && ub == 0)) begin
            e.err = 1'b1;
            lat   = 1;
        end else begin
            case (op)
                3'd0: begin
                    e.result = 16'(ua + ub);
                    c = (ua + ub) > 65535;
                    v = (sa + sb > 32767) || (sa + sb < -32768);
                end
                3'd1: begin
                    e.result = 16'(ua - ub);
                    c = (ua >= ub);
                    v = (sa - sb > 32767) || (sa - sb < -32768);
                end
                3'd2: e.result = a & b;
                3'd3: e.result = a | b;
                3'd4: begin
                    prod = longint'(ua) * longint'(ub);
                    e.result = 16'(prod % 65536);
                end
                default: e.result = 16'(ua / ub);
            endcase
            e.flags = {c, v, (e.result >= 16'h8000), (e.result == 16'd0)};
            lat = (op == 3'd4 || op == 3'd5) ? 2 + MD_WAIT : 2;
        end
        e.due = now + lat;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Drive one request from requester id, hold it until granted, then drop
    // valid just after the accepting edge.
    task automatic applyStimulus(input logic id, input logic [15:0] a,
                                 input logic [15:0] b, input logic [2:0] op);
        bit got;
        got = 1'b0;
        if (id == 1'b0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!rst && (id ? bus.req1_ready : bus.req0_ready)) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL accept_timeout: requester %0d ready stayed 0, expected 1", id);
        end
        @(posedge clk);
        #1;
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy && !bus.req0_valid && !bus.req1_valid) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_resp_valid"},  32'(bus.resp_valid),    32'd0);
        checkOutput({tag, "_resp_id"},     32'(bus.resp_id),       32'd0);
        checkOutput({tag, "_resp_result"}, 32'(bus.resp_result),   32'd0);
        checkOutput({tag, "_resp_flags"},  32'(bus.resp_flags),    32'd0);
        checkOutput({tag, "_resp_err"},    32'(bus.resp_err),      32'd0);
        checkOutput({tag, "_alu_a"},       32'(bus.alu_a),         32'd0);
        checkOutput({tag, "_alu_b"},       32'(bus.alu_b),         32'd0);
        checkOutput({tag, "_alu_sub"},     32'(bus.alu_sub),       32'd0);
        checkOutput({tag, "_alu_op"},      32'(bus.alu_op_select), 32'd0);
        checkOutput({tag, "_stat0"},       32'(bus.stat0_cnt),     32'd0);
        checkOutput({tag, "_stat1"},       32'(bus.stat1_cnt),     32'd0);
    endtask

    // Grant model and response monitor. Grants are checked before the
    // response so a handshake this cycle only frees the model next cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            busy    = 1'b0;
            pref    = 1'b0;
            seen_rv = 1'b0;
            cnt0    = 0;
            cnt1    = 0;
        end else begin
            g0 = !busy && bus.req0_valid && (!bus.req1_valid || pref == 1'b0);
            g1 = !busy && bus.req1_valid && !g0;
            checkOutput("req0_ready", 32'(bus.req0_ready), 32'(g0));
            checkOutput("req1_ready", 32'(bus.req1_ready), 32'(g1));
            if (g0) begin
                sbq.push_back(refModel(1'b0, bus.req0_a, bus.req0_b, bus.req0_op, cycle));
                busy = 1'b1;
                pref = 1'b1;
            end else if (g1) begin
                sbq.push_back(refModel(1'b1, bus.req1_a, bus.req1_b, bus.req1_op, cycle));
                busy = 1'b1;
                pref = 1'b0;
            end

            if (bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_resp: resp_valid=1 with no request outstanding, expected 0");
                end else begin
                    front = sbq[0];
                    if (!seen_rv) checkOutput("resp_latency", 32'(cycle), 32'(front.due));
                    checkOutput("resp_id",     32'(bus.resp_id),     32'(front.id));
                    checkOutput("resp_result", 32'(bus.resp_result), 32'(front.result));
                    checkOutput("resp_flags",  32'(bus.resp_flags),  32'(front.flags));
                    checkOutput("resp_err",    32'(bus.resp_err),    32'(front.err));
                    if (bus.resp_ready) begin
                        void'(sbq.pop_front());
                        busy = 1'b0;
                        if (front.id) cnt1++;
                        else          cnt0++;
                    end
                end
            end
            seen_rv = bus.resp_valid && !bus.resp_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rop;

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;

        $display("[TB] directed: add overflow, mul latency, error paths");
        bus.resp_ready = 1'b1;
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 3'b000);
        applyStimulus(1'b1, 16'h0003, 16'h0005, 3'b100);
        applyStimulus(1'b1, 16'h1234, 16'h0000, 3'b101);
        applyStimulus(1'b0, 16'h0055, 16'h0003, 3'b111);
        applyStimulus(1'b0, 16'h0005, 16'h0007, 3'b001);
        applyStimulus(1'b1, 16'hFFFF, 16'h0000, 3'b011);
        waitDrain();

        $display("[TB] directed: contention");
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'(i), 16'(i + 1), 3'b000);
            end
            begin
                for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(100 + i), 16'(7), 3'b010);
            end
        join
        waitDrain();

        $display("[TB] directed: response backpressure");
        bus.resp_ready = 1'b0;
        applyStimulus(1'b0, 16'd100, 16'd200, 3'b000);
        fork
            applyStimulus(1'b1, 16'd9, 16'd7, 3'b001);
        join_none
        repeat (7) @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        waitDrain();

        $display("[TB] random traffic");
        rand_done = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 30; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        applyStimulus(1'b0, 16'($urandom),
                                      ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom),
                                      3'($urandom_range(0, 7)));
                    end
                    for (int i = 0; i < 30; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        applyStimulus(1'b1, 16'($urandom),
                                      ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(0, 15)),
                                      3'($urandom_range(0, 7)));
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.resp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.resp_ready = 1'b1;
        waitDrain();

        $display("[TB] directed: reset during mul wait");
        ra  = 16'd3;
        rb  = 16'd5;
        rop = 3'b100;
        applyStimulus(1'b0, ra, rb, rop);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        // Requester 0 was granted last, so only a cleared pointer favours it.
        fork
            applyStimulus(1'b0, 16'd20, 16'd4, 3'b101);
            applyStimulus(1'b1, 16'd20, 16'd4, 3'b000);
        join
        waitDrain();

`ifdef ALU_ARB_STATS_EN
        checkOutput("stat0_cnt", 32'(bus.stat0_cnt), 32'(cnt0));
        checkOutput("stat1_cnt", 32'(bus.stat1_cnt), 32'(cnt1));
`else
        checkOutput("stat0_cnt", 32'(bus.stat0_cnt), 32'd0);
        checkOutput("stat1_cnt", 32'(bus.stat1_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
